// File: rtl/mem_wb_ctrl_pkg.sv
// Shared definitions for the MEM/WB boundary controller: memory opcodes,
// FSM state encoding and the word-alignment mask.
// Ports: none (package).
package mem_wb_ctrl_pkg;

  localparam logic [5:0] OP_LDW = 6'h23;
  localparam logic [5:0] OP_STW = 6'h2B;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_ctrl_timeout_cnt.sv
// Wait counter for an outstanding memory request; expire is high in the
// last cycle a request may still wait (count == TIMEOUT-1).
// Ports: clk, rst, clr (held while not requesting), en (count), expire.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  assign expire = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_wb_ctrl.sv
// MEM/WB boundary controller: decodes LDW/STW, runs the req/ready handshake
// with a variable-latency data memory, stalls the pipeline while it waits
// and registers the writeback value (1 cycle for ALU ops, >=2 for loads).
// Ports: in_* MEM-stage instruction, stall to IF..MEM, mem_* data-memory
// request, wb_* register-file write, align_err/bus_err one-cycle pulses.
module mem_wb_ctrl
  import mem_wb_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [5:0]  in_opcode,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_sdata,
  input  logic [4:0]  in_rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        align_err,
  output logic        bus_err
);

  state_t     state, state_nxt;
  logic       is_mem, aligned, expire;
  logic [4:0] lat_rd;
  logic       lat_load;

  assign is_mem  = in_valid && ((in_opcode == OP_LDW) || (in_opcode == OP_STW));
  assign aligned = is_aligned(in_alu);

  // Counter is held at zero outside REQ, so each request starts from 0.
  mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != ST_REQ),
    .en     (!mem_ready),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // stall never looks at mem_ready: REQ stalls unconditionally and DONE
  // releases the pipeline for the completing instruction.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_mem && aligned) begin
          stall     = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (mem_ready || expire) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      lat_rd    <= '0;
      lat_load  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wb_valid  <= 1'b0;
          align_err <= 1'b0;
          bus_err   <= 1'b0;
          if (in_valid && !is_mem) begin
            wb_valid <= 1'b1;
            wb_rd    <= in_rd;
            wb_data  <= in_alu;
          end else if (is_mem && !aligned) begin
            align_err <= 1'b1;
          end else if (is_mem) begin
            mem_req   <= 1'b1;
            mem_we    <= (in_opcode == OP_STW);
            mem_addr  <= in_alu & ~{30'd0, ALIGN_MASK};
            mem_wdata <= in_sdata;
            lat_rd    <= in_rd;
            lat_load  <= (in_opcode == OP_LDW);
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (lat_load) begin
              wb_valid <= 1'b1;
              wb_rd    <= lat_rd;
              wb_data  <= mem_rdata;
            end
          end else if (expire) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
          end
        end
        default: begin
          wb_valid  <= 1'b0;
          align_err <= 1'b0;
          bus_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_wb_ctrl.md
Name: mem_wb_ctrl

Overview:
- Sequences the MEM/WB boundary of the CPU pipeline: decides whether an instruction in the MEM stage needs a data-memory access (`LDW` / `STW`).
- Runs the request/ready handshake with a variable-latency data memory and stalls the pipeline until the access completes.
- Registers the writeback value: memory read data for `LDW`, the ALU result otherwise.
- Flags misaligned addresses and memory timeouts.

Parameters:
- TIMEOUT, 16, maximum cycles mem_req may wait for mem_ready before bus_err (>=2).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  MEM-stage instruction valid
- in_opcode  in  6  instruction opcode
- in_alu  in  32  ALU result; also the memory byte address for `LDW`/`STW`
- in_sdata  in  32  store data
- in_rd  in  5  destination register
- stall  out  1  hold IF..MEM stages this cycle
- mem_req  out  1  memory request
- mem_we  out  1  1=write (`STW`), 0=read
- mem_addr  out  32  word-aligned byte address
- mem_wdata  out  32  store data
- mem_ready  in  1  memory accepts/completes when mem_req&mem_ready
- mem_rdata  in  32  read data, valid in the mem_req&mem_ready cycle
- wb_valid  out  1  register-file write enable
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback value
- align_err  out  1  one-cycle pulse, misaligned access dropped
- bus_err  out  1  one-cycle pulse, memory timeout

Behaviour:
Decode:
- is_mem = in_valid & (in_opcode==`LDW` | in_opcode==`STW`).
- aligned = in_alu[1:0]==2'b00.

States: IDLE, REQ, DONE.

Reset:
- state=IDLE; mem_req=0; wb_valid=0; align_err=0; bus_err=0.
- mem_we/mem_addr/mem_wdata/wb_rd/wb_data=0; timeout counter=0.
- Reset mid-access drops mem_req next edge; no writeback occurs.

IDLE:
- in_valid & !is_mem: stall=0. Next edge: wb_valid=1, wb_rd=in_rd, wb_data=in_alu (latency 1).
- is_mem & !aligned: stall=0, no access. Next edge: align_err=1, wb_valid=0.
- is_mem & aligned: stall=1 combinationally. Next edge:
  - latch mem_addr=in_alu, mem_we=(opcode==`STW`), mem_wdata=in_sdata, rd, and the load flag;
  - mem_req=1, counter=0, wb_valid=0, go REQ.
- !in_valid: wb_valid=0 next edge.

REQ:
- stall=1; mem_req and its address/data/we held stable until the handshake.
- mem_ready=1: request completes this cycle. Next edge:
  - mem_req=0, go DONE;
  - load: wb_valid=1, wb_data=mem_rdata, wb_rd=latched rd;
  - store: wb_valid=0.
- mem_ready=0 and counter==TIMEOUT-1: abort. Next edge: mem_req=0, bus_err=1, wb_valid=0, go DONE.
- Otherwise counter++.

DONE:
- stall=0 for exactly one cycle; the pipeline advances the completed instruction.
- Input presented this cycle is the next instruction, but it is not decoded. Next edge: go IDLE, wb_valid=0, error pulses clear.
- The next instruction is evaluated in IDLE; a back-to-back memory op re-enters REQ one cycle later.

Minimum load latency:
- decode cycle + 1 REQ cycle; result visible on wb_* 2 edges after decode when mem_ready is already high.

Other rules:
- stall is purely a function of state, in_valid, opcode and in_alu[1:0]. It never depends on mem_ready (no combinational path mem_ready->stall).
- mem_ready while mem_req=0 is ignored.
- Writeback mux rule: wb_data=mem_rdata only for `LDW`; every other opcode takes in_alu.

Decomposition:
- Shared package/def: opcode constants `LDW`, `STW` (already in def.v), state encodings, address-alignment mask.
- One natural sub-module: mem_timeout_cnt. Clear/enable/expire counter parameterised by TIMEOUT, reset by rst and state!=REQ.

Test Plan:
1. rst held 3 cycles while mem_ready=1 -> all outputs 0, state IDLE; first cycle after release with in_valid=0 -> wb_valid stays 0.
2. ADD-type opcode, in_alu=0x0000_1234, in_rd=5 -> stall=0; next edge wb_valid=1, wb_rd=5, wb_data=0x0000_1234.
3. `LDW`, in_alu=0x100, mem_ready low 3 cycles then high with mem_rdata=0xDEAD_BEEF:
   - stall high for 5 cycles (decode + 4 REQ), mem_addr=0x100, mem_we=0;
   - then wb_valid=1, wb_data=0xDEAD_BEEF, then 1-cycle stall=0 in DONE.
4. `STW`, in_alu=0x204, in_sdata=0xA5A5_A5A5, mem_ready immediately -> mem_req for 1 cycle with mem_we=1, mem_wdata=0xA5A5_A5A5; wb_valid stays 0.
5. `LDW` at 0x102 -> no mem_req, stall=0, align_err pulses 1 cycle, wb_valid=0.
6. `LDW` with mem_ready tied 0, TIMEOUT=16 -> mem_req high exactly 16 cycles; then bus_err 1-cycle pulse, mem_req=0, wb_valid=0. Repeat with rst asserted at REQ cycle 5 -> mem_req=0 next edge, no bus_err.
